// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage
// Description : IF stage of an RV32IM 5-stage pipeline. Owns the program
//               counter, presents it to a combinational instruction memory
//               and registers the returned word into the IF/ID pipeline
//               register. Handles hazard-unit stall/flush, EX-stage redirect
//               and a sticky fetch fault for misaligned or out-of-range PCs.
//
// Ports:
//   clk               in   rising-edge clock
//   reset_n           in   asynchronous active-low reset
//   stall             in   hold PC and IF/ID contents
//   flush             in   load a bubble into IF/ID
//   branch_taken      in   EX-stage redirect request
//   branch_target     in   redirect PC
//   imem_address      out  instruction memory address (always equals PC)
//   imem_instruction  in   instruction word for imem_address (combinational)
//   ifid_pc           out  PC of the registered instruction
//   ifid_pc_plus4     out  ifid_pc + 4 (link value for JAL/JALR)
//   ifid_instruction  out  registered instruction
//   ifid_valid        out  1 = real instruction, 0 = bubble
//   fetch_fault       out  sticky fetch-fault flag
//   fault_addr        out  PC that raised the fault
//
// Revision    : 1.0 - initial release
// ============================================================================

module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned MEM_SIZE_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instruction,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_addr
);

    // Highest PC from which a full 32-bit word can still be fetched.
    localparam logic [31:0] C_MAX_PC = 32'(MEM_SIZE_BYTES - 4);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc_plus4;
    logic [31:0] r_ifid_instruction;
    logic        r_ifid_valid;
    logic        r_fetch_fault;
    logic [31:0] r_fault_addr;

    logic [31:0] w_pc_plus4;
    logic        w_pc_illegal;

    // PC + 4 wraps modulo 2^32; a wrapped PC is caught by the legality check
    // on the cycle it becomes the current PC.
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_pc_illegal = (r_pc[1:0] != 2'b00) || (r_pc > C_MAX_PC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= ST_BOOT;
            r_pc               <= RESET_PC;
            r_ifid_pc          <= 32'd0;
            r_ifid_pc_plus4    <= 32'd0;
            r_ifid_instruction <= NOP_INSTR;
            r_ifid_valid       <= 1'b0;
            r_fetch_fault      <= 1'b0;
            r_fault_addr       <= 32'd0;
        end else begin
            case (r_state)
                // First cycle out of reset: give memory a cycle with the reset
                // PC already presented before anything is registered.
                ST_BOOT: begin
                    r_ifid_instruction <= NOP_INSTR;
                    r_ifid_valid       <= 1'b0;
                    r_state            <= ST_RUN;
                end

                ST_RUN: begin
                    if (w_pc_illegal) begin
                        // The fault check on the current PC dominates every
                        // hazard and redirect input in this cycle.
                        r_ifid_instruction <= NOP_INSTR;
                        r_ifid_valid       <= 1'b0;
                        r_fault_addr       <= r_pc;
                        r_fetch_fault      <= 1'b1;
                        r_state            <= ST_FAULT;
                    end else if (branch_taken) begin
                        // Redirect wins over a stall: the stalled instruction
                        // is on the wrong path anyway.
                        r_pc               <= branch_target;
                        r_ifid_instruction <= NOP_INSTR;
                        r_ifid_valid       <= 1'b0;
                    end else if (stall) begin
                        if (flush) begin
                            r_ifid_instruction <= NOP_INSTR;
                            r_ifid_valid       <= 1'b0;
                        end
                    end else if (flush) begin
                        r_pc               <= w_pc_plus4;
                        r_ifid_instruction <= NOP_INSTR;
                        r_ifid_valid       <= 1'b0;
                    end else begin
                        r_pc               <= w_pc_plus4;
                        r_ifid_pc          <= r_pc;
                        r_ifid_pc_plus4    <= w_pc_plus4;
                        r_ifid_instruction <= imem_instruction;
                        r_ifid_valid       <= 1'b1;
                    end
                end

                ST_FAULT: begin
                    // Terminal until reset; keep feeding bubbles downstream.
                    r_ifid_instruction <= NOP_INSTR;
                    r_ifid_valid       <= 1'b0;
                end

                default: begin
                    r_state            <= ST_FAULT;
                    r_ifid_instruction <= NOP_INSTR;
                    r_ifid_valid       <= 1'b0;
                end
            endcase
        end
    end

    assign imem_address     = r_pc;
    assign ifid_pc          = r_ifid_pc;
    assign ifid_pc_plus4    = r_ifid_pc_plus4;
    assign ifid_instruction = r_ifid_instruction;
    assign ifid_valid       = r_ifid_valid;
    assign fetch_fault      = r_fetch_fault;
    assign fault_addr       = r_fault_addr;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Directed self-checking bench for instruction_fetch_stage with
//               a behavioural combinational instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_instruction_fetch_stage;

    localparam logic [31:0] c_nop   = 32'h0000_0013;
    localparam logic [31:0] c_addi1 = 32'h0010_0113;  // ADDI x2,x0,1   @20
    localparam logic [31:0] c_add   = 32'h0020_81B3;  // ADD  x3,x1,x2  @36
    localparam logic [31:0] c_addi3 = 32'h0031_0113;  // ADDI x2,x2,3   @52
    localparam logic [31:0] c_sub   = 32'h4020_81B3;  // SUB  x3,x1,x2  @68

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instruction;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fault_addr;

    logic [31:0] mem [0:255];

    int n_vec;
    int n_err;

    instruction_fetch_stage #(
        .RESET_PC       (32'h0000_0000),
        .NOP_INSTR      (32'h0000_0013),
        .MEM_SIZE_BYTES (1024)
    ) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .ifid_pc          (ifid_pc),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_instruction (ifid_instruction),
        .ifid_valid       (ifid_valid),
        .fetch_fault      (fetch_fault),
        .fault_addr       (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory; out-of-range reads return a NOP.
    always_comb begin
        imem_instruction = c_nop;
        if (imem_address < 32'd1024)
            imem_instruction = mem[imem_address[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("boot_valid", {31'd0, ifid_valid}, 32'd0);
        check("boot_pc",    imem_address,        32'd0);
        step();
        check("first_pc",    ifid_pc,             32'd0);
        check("first_valid", {31'd0, ifid_valid}, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        branch_taken  = 1'b1;
        branch_target = target;
        step();
        branch_taken  = 1'b0;
        check("redir_pc",    imem_address,        target);
        check("redir_valid", {31'd0, ifid_valid}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++)
            mem[i] = {i[11:0], 5'd0, 3'b000, 5'd1, 7'h13};  // ADDI x1,x0,i
        for (int i = 0; i < 5; i++)
            mem[i] = c_nop;
        mem[5]  = c_addi1;
        mem[9]  = c_add;
        mem[13] = c_addi3;
        mem[17] = c_sub;

        reset_n       = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;

        // ---------------- reset state ----------------
        #2 reset_n = 1'b0;
        #1;
        check("rst_pc",    imem_address,        32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_instr", ifid_instruction,    c_nop);
        check("rst_ifpc",  ifid_pc,             32'd0);
        check("rst_plus4", ifid_pc_plus4,       32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_faddr", fault_addr,          32'd0);
        step();
        release_reset();                       // fetched PC 0, PC now 4

        // ---------------- sequential fetch ----------------
        for (int k = 1; k <= 5; k++) begin
            step();
            check("seq_pc",    ifid_pc,             32'(4 * k));
            check("seq_valid", {31'd0, ifid_valid}, 32'd1);
        end
        check("addi_instr", ifid_instruction, c_addi1);
        check("addi_plus4", ifid_pc_plus4,    32'd24);
        step(); step(); step();                // fetch 24,28,32
        check("pre_stall_pc", imem_address, 32'd36);

        // ---------------- stall ----------------
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_addr",  imem_address,     32'd36);
            check("stall_ifpc",  ifid_pc,          32'd32);
            check("stall_instr", ifid_instruction, mem[8]);
        end
        stall = 1'b0;
        step();
        check("unstall_instr", ifid_instruction, c_add);
        check("unstall_pc",    ifid_pc,          32'd36);
        step();
        check("after_unstall_pc", ifid_pc, 32'd40);

        // ---------------- branch with stall ----------------
        stall = 1'b1;
        redirect(32'd68);
        stall = 1'b0;
        check("br_ifpc_held", ifid_pc, 32'd40);
        step();
        check("br_instr", ifid_instruction, c_sub);
        check("br_ifpc",  ifid_pc,          32'd68);
        check("br_plus4", ifid_pc_plus4,    32'd72);

        // ---------------- flush ----------------
        redirect(32'd52);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", {31'd0, ifid_valid}, 32'd0);
        check("flush_instr", ifid_instruction,    c_nop);
        check("flush_pc",    imem_address,        32'd56);
        step();
        check("post_flush_ifpc",  ifid_pc,             32'd56);
        check("post_flush_valid", {31'd0, ifid_valid}, 32'd1);

        // stall + flush: PC held, bubble, IF/ID PC held
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        check("sf_addr",  imem_address,        32'd60);
        check("sf_valid", {31'd0, ifid_valid}, 32'd0);
        check("sf_ifpc",  ifid_pc,             32'd56);

        // ---------------- reset mid-RUN at PC=40 ----------------
        redirect(32'd36);
        step();                                // fetch 36, PC now 40
        check("mid_pc",    imem_address,        32'd40);
        check("mid_valid", {31'd0, ifid_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_pc",    imem_address,        32'd0);
        check("async_valid", {31'd0, ifid_valid}, 32'd0);
        check("async_fault", {31'd0, fetch_fault}, 32'd0);
        release_reset();

        // ---------------- misaligned target ----------------
        redirect(32'd70);
        step();
        check("mis_fault", {31'd0, fetch_fault}, 32'd1);
        check("mis_faddr", fault_addr,          32'd70);
        check("mis_valid", {31'd0, ifid_valid}, 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'd0;
        step();
        branch_taken  = 1'b0;
        flush         = 1'b1;
        step();
        flush         = 1'b0;
        check("fault_valid", {31'd0, ifid_valid}, 32'd0);
        check("fault_pc",    imem_address,        32'd70);
        check("fault_hold",  fault_addr,          32'd70);
        check("fault_stick", {31'd0, fetch_fault}, 32'd1);

        // ---------------- reset while in FAULT ----------------
        reset_n = 1'b0;
        #1;
        check("frst_pc",    imem_address,         32'd0);
        check("frst_fault", {31'd0, fetch_fault}, 32'd0);
        check("frst_faddr", fault_addr,           32'd0);
        release_reset();

        // ---------------- last legal word, then PC+4 out of range ----------------
        redirect(32'd1020);
        step();
        check("edge_ifpc",  ifid_pc,               32'd1020);
        check("edge_valid", {31'd0, ifid_valid},   32'd1);
        check("edge_fault", {31'd0, fetch_fault},  32'd0);
        step();
        check("wrap_fault", {31'd0, fetch_fault},  32'd1);
        check("wrap_faddr", fault_addr,            32'd1024);

        // ---------------- out-of-range branch target ----------------
        reset_n = 1'b0;
        #1;
        release_reset();
        redirect(32'd1024);
        step();
        check("oor_fault", {31'd0, fetch_fault}, 32'd1);
        check("oor_faddr", fault_addr,          32'd1024);
        branch_taken  = 1'b1;
        branch_target = 32'd8;
        flush         = 1'b1;
        step();
        step();
        branch_taken  = 1'b0;
        flush         = 1'b0;
        check("oor_valid", {31'd0, ifid_valid}, 32'd0);
        check("oor_pc",    imem_address,        32'd1024);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
